// File: rtl/mac_feeder_if.sv
// mac_feeder_if -- bus bundle between a job controller / accumulator
// and the mac_feeder sequencer.
//
// Signals:
//   wr_en, wr_sel, wr_addr, wr_data : buffer write port (into the feeder)
//   start                           : job request (into the feeder)
//   busy                            : feeder is streaming or waiting
//   mac_in, mac_w, mac_vld          : activation/weight beat to the accumulator
//   mac_out                         : accumulated sum back from the accumulator
//   result, done                    : captured sum and its one-cycle strobe
//   mismatch                        : only with MAC_FEEDER_CHECK_EN defined
//
// Modports:
//   master : controller/accumulator side
//   slave  : mac_feeder side
`timescale 1ns/1ps

interface mac_feeder_if;
  logic                wr_en;
  logic                wr_sel;
  logic        [3:0]   wr_addr;
  logic signed [3:0]   wr_data;
  logic                start;
  logic                busy;
  logic signed [3:0]   mac_in;
  logic signed [3:0]   mac_w;
  logic                mac_vld;
  logic signed [11:0]  mac_out;
  logic signed [11:0]  result;
  logic                done;
`ifdef MAC_FEEDER_CHECK_EN
  logic                mismatch;
`endif

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start, mac_out,
    input  busy, mac_in, mac_w, mac_vld, result, done
`ifdef MAC_FEEDER_CHECK_EN
    , input mismatch
`endif
  );

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start, mac_out,
    output busy, mac_in, mac_w, mac_vld, result, done
`ifdef MAC_FEEDER_CHECK_EN
    , output mismatch
`endif
  );
endinterface

// File: rtl/mac_feeder.sv
// mac_feeder -- streams N_TAPS activation/weight pairs from two small
// buffers to an external accumulator, waits RES_LAT cycles for the sum to
// settle, then captures mac_out into result with a one-cycle done pulse.
//
// Parameters:
//   N_TAPS  : pairs streamed per job (2..15)
//   RES_LAT : cycles from the last streamed pair to the capture edge (1..7)
//
// Ports:
//   clk  : clock, rising edge
//   rstb : asynchronous reset, ACTIVE-HIGH despite the name
//   bus  : mac_feeder_if.slave (write port, start, beat outputs, mac_out,
//          result, done, busy, optional mismatch)
//
// Optional feature (macro MAC_FEEDER_CHECK_EN):
//   Keeps an internal 12-bit signed running sum of the streamed products
//   and flags mismatch when mac_out differs from it at capture. mismatch
//   holds until the next accepted start.
`timescale 1ns/1ps

module mac_feeder #(
  parameter int N_TAPS  = 9,
  parameter int RES_LAT = 2
) (
  input  logic          clk,
  input  logic          rstb,
  mac_feeder_if.slave   bus
);

  localparam int DATA_W = 4;
  localparam int COEF_W = 4;
  localparam int ACC_W  = 12;

  localparam logic [3:0] TAPS      = 4'(N_TAPS);
  localparam logic [3:0] LAST_BEAT = 4'(N_TAPS - 1);
  localparam logic [3:0] LAST_WAIT = 4'(RES_LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  // One counter serves both STREAM (beat index) and WAIT (latency count);
  // it restarts at 0 on every state change.
  logic [3:0] cnt_q;

  // Buffers are sized to the full 4-bit address space so the beat counter
  // and write address index them without width games; only entries below
  // N_TAPS are ever written.
  logic signed [DATA_W-1:0] act_mem [16];
  logic signed [COEF_W-1:0] wt_mem  [16];

  logic signed [ACC_W-1:0]  result_q;

  logic start_ok;
  logic wr_ok;
  logic beat_last;
  logic wait_last;
  logic capture;

  assign start_ok  = (state_q == IDLE) && bus.start;
  // Writes land only while nothing is being streamed from the buffers.
  assign wr_ok     = bus.wr_en && ((state_q == IDLE) || (state_q == DONE))
                     && (bus.wr_addr < TAPS);
  assign beat_last = (cnt_q == LAST_BEAT);
  assign wait_last = (cnt_q == LAST_WAIT);
  assign capture   = (state_q == WAIT) && wait_last;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok)  state_d = STREAM;
      STREAM:  if (beat_last) state_d = WAIT;
      WAIT:    if (wait_last) state_d = DONE;
      DONE:                   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        cnt_q <= '0;
      else if ((state_q == STREAM) || (state_q == WAIT))
        cnt_q <= cnt_q + 4'd1;
    end
  end

  // A write on the start edge lands here, and beat 0 reads the buffer in
  // the following cycle, so the job sees the new value without a bypass.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      for (int i = 0; i < 16; i++) begin
        act_mem[i] <= '0;
        wt_mem[i]  <= '0;
      end
    end else if (wr_ok) begin
      if (bus.wr_sel)
        wt_mem[bus.wr_addr]  <= bus.wr_data;
      else
        act_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb)
      result_q <= '0;
    else if (capture)
      result_q <= bus.mac_out;
  end

  // Beat outputs decode straight from state so reset silences them at once.
  always_comb begin
    bus.busy    = (state_q == STREAM) || (state_q == WAIT);
    bus.mac_vld = (state_q == STREAM);
    bus.done    = (state_q == DONE);
    bus.result  = result_q;
    bus.mac_in  = '0;
    bus.mac_w   = '0;
    if (state_q == STREAM) begin
      bus.mac_in = act_mem[cnt_q];
      bus.mac_w  = wt_mem[cnt_q];
    end
  end

`ifdef MAC_FEEDER_CHECK_EN
  // 4x4 signed product, sign-extended from 8 bits to the accumulator width.
  function automatic logic signed [ACC_W-1:0] prod_ext(
    input logic signed [DATA_W-1:0] a,
    input logic signed [COEF_W-1:0] w
  );
    logic signed [7:0] ae;
    logic signed [7:0] we;
    logic signed [7:0] p;
    ae = {{(8-DATA_W){a[DATA_W-1]}}, a};
    we = {{(8-COEF_W){w[COEF_W-1]}}, w};
    p  = ae * we;
    return {{(ACC_W-8){p[7]}}, p};
  endfunction

  logic signed [ACC_W-1:0] sum_q;
  logic                    mismatch_q;

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      sum_q      <= '0;
      mismatch_q <= 1'b0;
    end else begin
      if (start_ok) begin
        sum_q      <= '0;
        mismatch_q <= 1'b0;
      end else if (state_q == STREAM) begin
        sum_q <= sum_q + prod_ext(act_mem[cnt_q], wt_mem[cnt_q]);
      end
      if (capture)
        mismatch_q <= (bus.mac_out != sum_q);
    end
  end

  assign bus.mismatch = mismatch_q;
`endif

endmodule
